shift_sched: RTL

Round-robin scheduler that shares one parallel-load/serial-out shift unit between REQS requesters.
- Arbitrates pending requests and latches the winner's word.
- Pulses a load into the shifter and waits for the shifter's end-of-shift flag.
- Acknowledges the requester, then enforces an inter-frame gap before the next grant.
- Sits between the top-level wrapper pins and the shift datapath instance.

---
 rtl/shift_sched_pkg.sv | 16 +
 rtl/shift_sched_rr_arbiter.sv | 29 ++
 rtl/shift_sched.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/shift_sched_pkg.sv
// Shared types and default constants for the shift scheduler.
package shift_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_GAP   = 2'd3
  } state_e;

  localparam int DEF_REQS   = 4;
  localparam int DEF_BITS   = 8;
  localparam int DEF_GAP    = 2;
  localparam int TMO_MARGIN = 4;

endpackage

// File: rtl/shift_sched_rr_arbiter.sv
// Combinational round-robin pick: first set request bit at or above ptr, wrapping mod REQS.
module rr_arbiter #(
  parameter int REQS = 4,
  localparam int IW  = $clog2(REQS)
) (
  input  logic [REQS-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [IW-1:0]   grant,
  output logic            vld
);

  logic [IW:0] sum;

  // Walk from the farthest offset down so the nearest requester is written last and wins.
  always_comb begin
    grant = '0;
    vld   = 1'b0;
    sum   = '0;
    for (int k = REQS - 1; k >= 0; k--) begin
      sum = {1'b0, ptr} + (IW+1)'(k);
      if (sum >= (IW+1)'(REQS)) sum = sum - (IW+1)'(REQS);
      if (req[sum[IW-1:0]]) begin
        grant = sum[IW-1:0];
        vld   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/shift_sched.sv
// Round-robin scheduler sharing one parallel-load/serial-out shifter among REQS requesters.
// Optional shift watchdog enabled by defining SHIFT_SCHED_TIMEOUT_EN.
module shift_sched import shift_sched_pkg::*; #(
  parameter int REQS = DEF_REQS,
  parameter int BITS = DEF_BITS,
  parameter int GAP  = DEF_GAP,
  localparam int IW  = $clog2(REQS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [REQS-1:0]    req,
  input  logic [REQS*BITS-1:0] data,
  output logic [REQS-1:0]    ack,
  output logic               sh_load,
  output logic [BITS-1:0]    sh_d,
  input  logic               sh_eos,
  output logic               busy,
  output logic [IW-1:0]      grant_id,
  output logic               err
);

  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

  state_e          state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   gid_q, gid_d;
  logic [BITS-1:0] shd_q, shd_d;
  logic [REQS-1:0] ack_q, ack_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic            err_q, err_d;
  logic [IW-1:0]   arb_gnt;
  logic            arb_vld;
  logic [BITS-1:0] sel_word;
  logic [IW-1:0]   ptr_next;

`ifdef SHIFT_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(BITS + TMO_MARGIN);
  logic [TW-1:0] tmo_q, tmo_d;
`endif

  rr_arbiter #(.REQS(REQS)) u_arb (
    .req   (req),
    .ptr   (ptr_q),
    .grant (arb_gnt),
    .vld   (arb_vld)
  );

  always_comb begin
    sel_word = '0;
    for (int i = 0; i < REQS; i++)
      if (arb_gnt == IW'(i)) sel_word = data[i*BITS +: BITS];
  end

  assign ptr_next = (gid_q == IW'(REQS - 1)) ? '0 : gid_q + IW'(1);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gid_d   = gid_q;
    shd_d   = shd_q;
    ack_d   = '0;
    gap_d   = gap_q;
    err_d   = 1'b0;
`ifdef SHIFT_SCHED_TIMEOUT_EN
    tmo_d   = tmo_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (arb_vld) begin
          gid_d   = arb_gnt;
          shd_d   = sel_word;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
`ifdef SHIFT_SCHED_TIMEOUT_EN
        tmo_d   = '0;
`endif
        state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (sh_eos) begin
          ack_d[gid_q] = 1'b1;
          ptr_d        = ptr_next;
          gap_d        = GW'(GAP - 1);
          state_d      = (GAP > 0) ? ST_GAP : ST_IDLE;
        end
`ifdef SHIFT_SCHED_TIMEOUT_EN
        // Abandon the frame without ack; the requester loses its turn.
        else if (tmo_q == TW'(BITS + TMO_MARGIN - 1)) begin
          err_d   = 1'b1;
          ptr_d   = ptr_next;
          gap_d   = GW'(GAP - 1);
          state_d = (GAP > 0) ? ST_GAP : ST_IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
`endif
      end
      ST_GAP: begin
        if (gap_q == '0) state_d = ST_IDLE;
        else             gap_d   = gap_q - GW'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      gid_q   <= '0;
      shd_q   <= '0;
      ack_q   <= '0;
      gap_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gid_q   <= gid_d;
      shd_q   <= shd_d;
      ack_q   <= ack_d;
      gap_q   <= gap_d;
      err_q   <= err_d;
    end
  end

`ifdef SHIFT_SCHED_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) tmo_q <= '0;
    else     tmo_q <= tmo_d;
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign sh_load  = (state_q == ST_LOAD);
  assign busy     = (state_q != ST_IDLE);
  assign ack      = ack_q;
  assign grant_id = gid_q;
  assign sh_d     = shd_q;

endmodule
